// File: rtl/cu_ls_pkg.sv
// Shared definitions for the load/store sequencer: opcode constants,
// mem_size encoding, FSM states and a byte-lane mask helper.
package cu_ls_pkg;

  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STURW  = 11'b10111000000;
  localparam logic [10:0] OP_LDURSW = 11'b10111000100;
  localparam logic [10:0] OP_STURH  = 11'b01111000000;
  localparam logic [10:0] OP_LDURH  = 11'b01111000010;
  localparam logic [10:0] OP_STURB  = 11'b00111000000;
  localparam logic [10:0] OP_LDURB  = 11'b00111000010;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE,
    S_FAULT
  } state_e;

  // Mask covering the low 2**size bytes of a 64-bit value.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    m = '1;
    if (size != 2'b11) m = (64'd1 << (7'd8 << size)) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/ls_decode.sv
// Opcode decoder for the load/store sequencer.
// Ports: opcode (IR[31:21]) in; legal_c, load_c, signed_c, size_c out
// (combinational).
module ls_decode
  import cu_ls_pkg::*;
(
  input  logic [10:0] opcode,
  output logic        legal_c,
  output logic        load_c,
  output logic        signed_c,
  output logic [1:0]  size_c
);

  always_comb begin
    legal_c  = 1'b1;
    load_c   = 1'b0;
    signed_c = 1'b0;
    size_c   = SZ_BYTE;
    case (opcode)
      OP_STUR:   size_c = SZ_DOUBLE;
      OP_LDUR:   begin load_c = 1'b1; size_c = SZ_DOUBLE; end
      OP_STURW:  size_c = SZ_WORD;
      OP_LDURSW: begin load_c = 1'b1; signed_c = 1'b1; size_c = SZ_WORD; end
      OP_STURH:  size_c = SZ_HALF;
      OP_LDURH:  begin load_c = 1'b1; size_c = SZ_HALF; end
      OP_STURB:  size_c = SZ_BYTE;
      OP_LDURB:  begin load_c = 1'b1; size_c = SZ_BYTE; end
      default:   legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/cu_ls_seq.sv
// Load/store sequencer: decodes an LDUR/STUR-family instruction, splits the
// access into bus-width beats, assembles load data and writes it back.
// Ports: clock, reset_n (sync, active low); start, IR, base_data, store_data
// request inputs; mem_* memory beat interface; busy/done/fault status;
// rf_we/rf_da/rf_wdata register-file writeback. All outputs registered.
module cu_ls_seq
  import cu_ls_pkg::*;
#(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BUS_W    = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       IR,
  input  logic [DATA_W-1:0] base_data,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_ready,
  input  logic [BUS_W-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [63:0]       mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  output logic [1:0]        mem_size,
  output logic              rf_we,
  output logic [4:0]        rf_da,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int unsigned BUS_B  = BUS_W / 8;
  localparam int unsigned BUS_LG = $clog2(BUS_B);
  localparam int unsigned CNT_W  = $clog2(WAIT_MAX + 1);
  localparam logic [1:0]  BUS_SZ = 2'(BUS_LG);

  state_e           state;
  logic [63:0]      st_data;
  logic [63:0]      acc;
  logic [4:0]       rt;
  logic [1:0]       size;
  logic [1:0]       beat_sz;
  logic             is_load;
  logic             is_signed;
  logic [2:0]       beat;
  logic [2:0]       last_beat;
  logic [CNT_W-1:0] stall;

  logic       dec_legal;
  logic       dec_load;
  logic       dec_signed;
  logic [1:0] dec_size;

  ls_decode u_decode (
    .opcode   (IR[31:21]),
    .legal_c  (dec_legal),
    .load_c   (dec_load),
    .signed_c (dec_signed),
    .size_c   (dec_size)
  );

  // IR[11:10] carry no meaning for these opcodes.
  logic unused_ir;
  assign unused_ir = ^IR[11:10];

  // Effective address and beat geometry for the incoming request.
  logic [63:0] ea_c;
  logic [1:0]  dec_beat_sz_c;
  logic [2:0]  dec_last_c;
  assign ea_c          = 64'(base_data) + {{55{IR[20]}}, IR[20:12]};
  assign dec_beat_sz_c = (dec_size > BUS_SZ) ? BUS_SZ : dec_size;
  assign dec_last_c    = (dec_size > BUS_SZ) ?
                         3'((4'd1 << (dec_size - BUS_SZ)) - 4'd1) : 3'd0;

  // Byte slice k of the store data, on the low lanes, unused lanes zero.
  function automatic logic [BUS_W-1:0] beat_slice(input logic [63:0] data,
                                                  input logic [2:0]  k,
                                                  input logic [1:0]  bsz);
    logic [63:0] sh;
    sh = data >> (32'(k) * BUS_W);
    return BUS_W'(sh & size_mask(bsz));
  endfunction

  // Little-endian load assembly including the beat currently returning.
  logic [63:0] acc_next_c;
  logic [63:0] load_val_c;
  assign acc_next_c = acc | (64'(mem_rdata) << (32'(beat) * BUS_W));

  always_comb begin
    load_val_c = acc_next_c & size_mask(size);
    if (is_signed) load_val_c = {{32{load_val_c[31]}}, load_val_c[31:0]};
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      st_data   <= '0;
      acc       <= '0;
      rt        <= '0;
      size      <= '0;
      beat_sz   <= '0;
      is_load   <= 1'b0;
      is_signed <= 1'b0;
      beat      <= '0;
      last_beat <= '0;
      stall     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      rf_we     <= 1'b0;
      rf_da     <= '0;
      rf_wdata  <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (dec_legal) begin
              state     <= S_ISSUE;
              st_data   <= 64'(store_data);
              acc       <= '0;
              rt        <= IR[4:0];
              size      <= dec_size;
              beat_sz   <= dec_beat_sz_c;
              is_load   <= dec_load;
              is_signed <= dec_signed;
              beat      <= '0;
              last_beat <= dec_last_c;
              stall     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= !dec_load;
              mem_addr  <= ea_c;
              mem_size  <= dec_beat_sz_c;
              mem_wdata <= dec_load ? '0 :
                           beat_slice(64'(store_data), 3'd0, dec_beat_sz_c);
            end else begin
              state <= S_FAULT;
              fault <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (mem_ready) begin
            acc <= acc_next_c;
            if (beat == last_beat) begin
              state     <= S_DONE;
              done      <= 1'b1;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_size  <= '0;
              if (is_load) begin
                rf_we    <= 1'b1;
                rf_da    <= rt;
                rf_wdata <= DATA_W'(load_val_c);
              end
            end else begin
              beat      <= beat + 3'd1;
              stall     <= '0;
              mem_addr  <= mem_addr + 64'(BUS_B);
              mem_wdata <= is_load ? '0 : beat_slice(st_data, beat + 3'd1, beat_sz);
            end
          end else if (stall == CNT_W'(WAIT_MAX - 1)) begin
            // This stalled cycle brings the counter to WAIT_MAX.
            state     <= S_FAULT;
            fault     <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= '0;
          end else begin
            stall <= stall + CNT_W'(1);
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          rf_da    <= '0;
          rf_wdata <= '0;
        end

        S_FAULT: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_ls_seq.sv
// Randomized self-checking bench for cu_ls_seq (BUS_W = 32) against a
// transaction-level model of the load/store rules.
module tb_cu_ls_seq;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned BUS_W    = 32;
  localparam int unsigned WAIT_MAX = 15;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       IR = '0;
  logic [DATA_W-1:0] base_data = '0;
  logic [DATA_W-1:0] store_data = '0;
  logic              mem_ready = 1'b0;
  logic [BUS_W-1:0]  mem_rdata = '0;
  logic              busy, done, fault, mem_req, mem_we, rf_we;
  logic [63:0]       mem_addr;
  logic [BUS_W-1:0]  mem_wdata;
  logic [1:0]        mem_size;
  logic [4:0]        rf_da;
  logic [DATA_W-1:0] rf_wdata;

  always #5 clock = ~clock;

  cu_ls_seq #(.DATA_W(DATA_W), .BUS_W(BUS_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .IR         (IR),
    .base_data  (base_data),
    .store_data (store_data),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_size   (mem_size),
    .rf_we      (rf_we),
    .rf_da      (rf_da),
    .rf_wdata   (rf_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [10:0] ops [8] = '{11'b11111000000, 11'b11111000010, 11'b10111000000,
                           11'b10111000100, 11'b01111000000, 11'b01111000010,
                           11'b00111000000, 11'b00111000010};

  // Opcode table straight from the instruction definitions.
  function automatic void op_info(input logic [10:0] op, output bit legal,
                                  output int bytes, output bit load, output bit sgn);
    legal = 1'b1; load = 1'b0; sgn = 1'b0; bytes = 0;
    case (op)
      11'b11111000000: bytes = 8;
      11'b11111000010: begin bytes = 8; load = 1'b1; end
      11'b10111000000: bytes = 4;
      11'b10111000100: begin bytes = 4; load = 1'b1; sgn = 1'b1; end
      11'b01111000000: bytes = 2;
      11'b01111000010: begin bytes = 2; load = 1'b1; end
      11'b00111000000: bytes = 1;
      11'b00111000010: begin bytes = 1; load = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] byte_mask(input int nbytes);
    if (nbytes >= 8) return '1;
    return (64'd1 << (8 * nbytes)) - 64'd1;
  endfunction

  // One transaction. st0/st1 = stall cycles before mem_ready on beat 0/1;
  // a negative value means mem_ready never comes.
  task automatic run_txn(input logic [10:0] op, input logic [63:0] base,
                         input logic [8:0] imm, input logic [4:0] rt,
                         input logic [63:0] sd, input logic [31:0] rd0,
                         input logic [31:0] rd1, input int st0, input int st1);
    bit legal, load, sgn;
    int bytes, nbeats, bb, sz_log;
    logic [63:0] ea, acc, expv, exp_wd;
    logic [31:0] rd [2];
    int st [2];
    op_info(op, legal, bytes, load, sgn);
    rd[0] = rd0; rd[1] = rd1; st[0] = st0; st[1] = st1;

    @(negedge clock);
    IR = {op, imm, 2'b00, 5'($urandom), rt};
    base_data = base;
    store_data = sd;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    if (!legal) begin
      check("ill_fault", fault, 1);
      check("ill_req", mem_req, 0);
      check("ill_busy", busy, 1);
      start = 1'b1;                      // ignored: arrives with fault
      IR = {ops[1], 9'h0, 2'b00, 5'd0, 5'd1};
      @(negedge clock);
      start = 1'b0;
      check("ill_after_busy", busy, 0);
      check("ill_after_fault", fault, 0);
      check("ill_after_req", mem_req, 0);
      return;
    end

    ea = base + {{55{imm[8]}}, imm};
    nbeats = (bytes > 4) ? bytes / 4 : 1;
    bb = (bytes > 4) ? 4 : bytes;
    sz_log = $clog2(bb);
    acc = '0;

    for (int k = 0; k < nbeats; k++) begin
      int ncyc;
      ncyc = (st[k] < 0) ? int'(WAIT_MAX) : st[k] + 1;
      exp_wd = load ? 64'd0 : ((sd >> (32 * k)) & byte_mask(bb));
      for (int c = 0; c < ncyc; c++) begin
        check("beat_req", mem_req, 1);
        check("beat_addr", mem_addr, ea + 64'(4 * k));
        check("beat_we", mem_we, {63'd0, !load});
        check("beat_size", 64'(mem_size), 64'(sz_log));
        if (!load) check("beat_wdata", 64'(mem_wdata), exp_wd);
        check("beat_busy", busy, 1);
        if (st[k] >= 0 && c == st[k]) begin
          mem_ready = 1'b1;
          mem_rdata = rd[k];
          start = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          start = 1'($urandom_range(0, 1));   // must be ignored while busy
          IR = {ops[$urandom_range(0, 7)], 9'($urandom), 2'b00, 10'($urandom)};
        end
        @(negedge clock);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      if (st[k] < 0) begin
        check("to_fault", fault, 1);
        check("to_req", mem_req, 0);
        check("to_rf_we", rf_we, 0);
        check("to_busy", busy, 1);
        start = 1'b1;                    // ignored: arrives with fault
        @(negedge clock);
        start = 1'b0;
        check("to_after_busy", busy, 0);
        check("to_after_fault", fault, 0);
        check("to_after_rf_we", rf_we, 0);
        return;
      end
      acc = acc | (64'(rd[k]) << (32 * k));
    end

    expv = acc & byte_mask(bytes);
    if (sgn) expv = {{32{expv[31]}}, expv[31:0]};
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_req", mem_req, 0);
    check("done_fault", fault, 0);
    check("done_rf_we", rf_we, {63'd0, load});
    if (load) begin
      check("done_rf_da", 64'(rf_da), 64'(rt));
      check("done_rf_wdata", rf_wdata, expv);
    end
    start = 1'b1;                        // ignored: arrives with done
    @(negedge clock);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_rf_we", rf_we, 0);
    check("post_req", mem_req, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_addr", mem_addr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_ctl", 64'({busy, done, fault, mem_req, mem_we, mem_size, rf_we, rf_da, mem_wdata}), 0);
    reset_n = 1'b1;

    // Two-beat LDUR with negative offset
    run_txn(ops[1], 64'h1000, 9'h1F8, 5'd3, 64'($urandom), 32'h89ABCDEF, 32'h01234567, 0, 0);
    // LDURSW sign extension
    run_txn(ops[3], 64'h2000, 9'h010, 5'd9, 64'd0, 32'h80000001, 32'h0, 1, 0);
    // STURB with 3 stall cycles
    run_txn(ops[6], 64'h3000, 9'h003, 5'd2, 64'h1122334455667700 | 64'hAB, 32'h0, 32'h0, 3, 0);
    // Timeout on the only beat
    run_txn(ops[7], 64'h4000, 9'h0, 5'd4, 64'd0, 32'h0, 32'h0, -1, 0);
    // Illegal opcode 0
    run_txn(11'h000, 64'h5000, 9'h0, 5'd5, 64'd0, 32'h0, 32'h0, 0, 0);
    // Ready arrives on the last permitted stall cycle
    run_txn(ops[0], 64'h6000, 9'h0FF, 5'd6, 64'hDEADBEEFCAFEF00D, 32'h0, 32'h0,
            int'(WAIT_MAX) - 1, int'(WAIT_MAX) - 1);
    // Address wrap across 2**64
    run_txn(ops[1], 64'hFFFF_FFFF_FFFF_FFFC, 9'h0, 5'd7, 64'd0, 32'h13579BDF, 32'h2468ACE0, 0, 2);
    // Halfword load must drop upper garbage lanes
    run_txn(ops[5], 64'h7001, 9'h1FF, 5'd8, 64'd0, 32'hFFFF8001, 32'h0, 0, 0);

    // Reset during the second beat of an LDUR
    @(negedge clock);
    IR = {ops[1], 9'h0, 2'b00, 5'd1, 5'd7};
    base_data = 64'h8000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    @(negedge clock);
    mem_ready = 1'b0;
    check("mid_beat2_addr", mem_addr, 64'h8004);
    reset_n = 1'b0;
    @(negedge clock);
    check("midrst_addr", mem_addr, 0);
    check("midrst_rf_wdata", rf_wdata, 0);
    check("midrst_ctl", 64'({busy, done, fault, mem_req, mem_we, mem_size, rf_we, rf_da, mem_wdata}), 0);
    reset_n = 1'b1;
    mem_ready = 1'b1;                    // a stray ready must not revive it
    repeat (3) begin
      @(negedge clock);
      check("midrst_no_rf_we", rf_we, 0);
      check("midrst_idle", busy, 0);
    end
    mem_ready = 1'b0;
    run_txn(ops[1], 64'h8000, 9'h0, 5'd7, 64'd0, 32'h11111111, 32'h22222222, 0, 0);

    // Randomized transactions
    for (int i = 0; i < 200; i++) begin
      int sel;
      logic [10:0] op;
      int s0, s1;
      sel = $urandom_range(0, 11);
      op = ops[$urandom_range(0, 7)];
      s0 = (($urandom % 6) == 0) ? int'(WAIT_MAX) - 1 : int'($urandom_range(0, 4));
      s1 = int'($urandom_range(0, 4));
      if (sel == 8) op = 11'($urandom);
      if (sel == 9) s0 = -1;
      run_txn(op, {$urandom, $urandom}, 9'($urandom), 5'($urandom),
              {$urandom, $urandom}, $urandom, $urandom, s0, s1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_ls_seq.md
CU_LS_SEQ -- requirements
Module: cu_ls_seq

Interface
REQ-001 Parameter DATA_W, 64, register/data width in bits.
REQ-002 Parameter BUS_W, 32, memory bus width in bits; legal values are 8, 16, 32 and 64, with BUS_W <= DATA_W.
REQ-003 Parameter WAIT_MAX, 15, maximum consecutive stalled cycles per beat before fault; minimum 1.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a load/store held in IR.
REQ-007 IR  in  32  instruction word; opcode is IR[31:21], imm9 is IR[20:12], Rn is IR[9:5], Rt is IR[4:0].
REQ-008 base_data  in  DATA_W  Rn value, sampled with start.
REQ-009 store_data  in  DATA_W  Rt value, sampled with start.
REQ-010 mem_ready  in  1  memory accepts or returns the current beat.
REQ-011 mem_rdata  in  BUS_W  read data, valid when mem_req && mem_ready && !mem_we.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 fault  out  1  one-cycle pulse on illegal opcode or timeout.
REQ-015 mem_req / mem_we  out  1 / 1  beat request and its write qualifier.
REQ-016 mem_addr  out  64  byte address of the current beat.
REQ-017 mem_wdata  out  BUS_W  store data for the current beat.
REQ-018 mem_size  out  2  log2 of the beat byte count.
REQ-019 rf_we / rf_da / rf_wdata  out  1 / 5 / DATA_W  register-file writeback port.

Function
REQ-020 Opcodes SHALL map as follows:
- STUR 11111000000 and LDUR 11111000010: 8 bytes.
- STURW 10111000000 and LDURSW 10111000100: 4 bytes; LDURSW sign-extends.
- STURH 01111000000 and LDURH 01111000010: 2 bytes.
- STURB 00111000000 and LDURB 00111000010: 1 byte.
- Any other opcode is illegal.
REQ-021 The FSM SHALL have states IDLE, ISSUE, DONE and FAULT; start is ignored unless the FSM is in IDLE.
REQ-022 On start with a legal opcode, the block SHALL latch the following and go to ISSUE next cycle:
- EA = base_data + sign-extended imm9, in 64-bit wrap-around arithmetic.
- store_data, Rt, the size, and the load/signed flags.
REQ-023 On start with an illegal opcode, the block SHALL go to FAULT; no mem_req is issued.
REQ-024 Beat count SHALL be max(1, bytes/(BUS_W/8)), and the beat size SHALL be min(bytes, BUS_W/8).
- Beat k SHALL use mem_addr = EA + k*(BUS_W/8), with 64-bit wrap.
- Store beat k SHALL drive byte slice k of store_data on the low lanes of mem_wdata; unused lanes are 0.
REQ-025 In ISSUE, mem_req SHALL be 1, and mem_addr, mem_we, mem_size and mem_wdata SHALL stay stable until mem_ready.
- A beat completes on mem_req && mem_ready.
- The next beat, if any, is issued the following cycle with no idle gap.
REQ-026 Loads SHALL assemble beats little-endian; beat 0 fills the least-significant bytes.
- LDURSW SHALL sign-extend from bit 31.
- All other loads SHALL zero-extend to DATA_W.
REQ-027 One cycle after the last beat completes, the FSM SHALL enter DONE.
- done = 1 for that cycle.
- For loads: rf_we = 1, rf_da = Rt, rf_wdata = the assembled value, in the same cycle.
- The FSM returns to IDLE next cycle.
REQ-028 A per-beat stall counter SHALL clear on each beat issue and increment each ISSUE cycle with mem_ready = 0.
- When it reaches WAIT_MAX, the FSM SHALL enter FAULT and drop mem_req.
- A beat whose mem_ready arrives in the same cycle the counter reaches WAIT_MAX completes normally.
REQ-029 FAULT SHALL last one cycle with fault = 1, then return to IDLE; rf_we SHALL stay 0.
REQ-030 A start arriving in the same cycle as done or fault SHALL be ignored.

Reset
REQ-031 While reset_n = 0 at a clock edge, the block SHALL:
- set the state to IDLE and clear all counters and latched fields;
- drive every output to 0, including mid-operation.
REQ-032 An interrupted transfer SHALL NOT resume, and SHALL produce no rf_we after reset.

Structure
REQ-033 Package cu_ls_pkg SHALL hold:
- the eight opcode constants;
- the mem_size encoding (00 byte, 01 half, 10 word, 11 double);
- the FSM state enumeration.
REQ-034 Combinational sub-module ls_decode SHALL map an opcode to {legal, is_load, is_signed, size}; the FSM and datapath stay in cu_ls_seq.

Verification
REQ-035 BUS_W=32, LDUR, base 0x1000, imm9 = -8, Rt = 3, rdata 0x89ABCDEF then 0x01234567:
- beats at 0xFF8 and 0xFFC;
- rf_wdata = 0x0123456789ABCDEF, rf_da = 3, done one cycle after the second beat.
REQ-036 BUS_W=32, LDURSW, rdata 0x80000001 -> one beat, rf_wdata = 0xFFFFFFFF80000001.
REQ-037 BUS_W=32, STURB, store_data 0x...00AB, mem_ready delayed 3 cycles:
- one beat with mem_we = 1, mem_size = 00, mem_wdata = 0x000000AB held stable for all 4 cycles;
- done follows; rf_we stays 0.
REQ-038 BUS_W=32, WAIT_MAX=15, mem_ready held at 0 -> fault pulses after 15 stalled cycles, then busy = 0.
REQ-039 Opcode 0x000 with start -> fault next cycle, no mem_req; start asserted while busy is ignored.
REQ-040 reset_n = 0 during beat 2 of an LDUR -> all outputs 0 next cycle, no rf_we, and a fresh start then completes normally.
